// File: rtl/ddr3_pkg.sv
`default_nettype none
// ============================================================================
// ddr3_pkg : shared DDR3 write-path types and constants
// Rev 1.0
// ============================================================================
package ddr3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_WL = 2'd1,
    ST_BURST   = 2'd2
  } wr_ser_state_t;

  localparam int C_BL8        = 8;
  localparam int C_BEAT_CNT_W = 4;
  localparam int C_WL_MIN     = 1;
  localparam int C_WL_MAX     = 15;

endpackage : ddr3_pkg
`default_nettype wire

// File: rtl/write_burst_serializer_if.sv
`default_nettype none
// ============================================================================
// write_burst_serializer_if : data-path handshake plus PHY write-side signals
// Rev 1.0
// ============================================================================
interface write_burst_serializer_if
  import ddr3_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DRAM_WIDTH = 8
);

  logic [DATA_WIDTH-1:0]   write_data;
  logic                    write_data_valid;
  logic                    write_data_ready;
  logic                    wr_start;
  logic [DRAM_WIDTH-1:0]   phy_wr_dq;
  logic                    phy_wr_dm;
  logic                    phy_wr_dqs_en;
  logic [C_BEAT_CNT_W-1:0] phy_burst_cnt;
  logic                    wr_done;
  logic                    wr_underrun;
  logic                    cmd_error;
  logic                    busy;

  modport master (
    output write_data, write_data_valid, wr_start,
    input  write_data_ready, phy_wr_dq, phy_wr_dm, phy_wr_dqs_en,
    input  phy_burst_cnt, wr_done, wr_underrun, cmd_error, busy
  );

  modport slave (
    input  write_data, write_data_valid, wr_start,
    output write_data_ready, phy_wr_dq, phy_wr_dm, phy_wr_dqs_en,
    output phy_burst_cnt, wr_done, wr_underrun, cmd_error, busy
  );

endinterface : write_burst_serializer_if
`default_nettype wire

// File: rtl/write_burst_serializer.sv
`default_nettype none
// ============================================================================
// write_burst_serializer : one data-path word -> one DDR3 write burst, LSB first
// Rev 1.0
// ============================================================================
module write_burst_serializer
  import ddr3_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int DRAM_WIDTH    = 8,
  parameter int BURST_LENGTH  = C_BL8,
  parameter int WRITE_LATENCY = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  write_burst_serializer_if.slave  bus
);

  localparam int C_LAT_W = $clog2(C_WL_MAX);
  localparam logic [C_BEAT_CNT_W-1:0] C_LAST_BEAT = C_BEAT_CNT_W'(BURST_LENGTH - 1);
  localparam logic [C_LAT_W-1:0]      C_LAT_INIT  =
      (WRITE_LATENCY >= 2) ? C_LAT_W'(WRITE_LATENCY - 2) : '0;

  if (DATA_WIDTH != DRAM_WIDTH * BURST_LENGTH) begin : g_bad_width
    $error("write_burst_serializer: DATA_WIDTH must equal DRAM_WIDTH*BURST_LENGTH");
  end
  if ((WRITE_LATENCY < C_WL_MIN) || (WRITE_LATENCY > C_WL_MAX)) begin : g_bad_wl
    $error("write_burst_serializer: WRITE_LATENCY out of range 1..15");
  end
  if ((BURST_LENGTH < 1) || (BURST_LENGTH > (1 << C_BEAT_CNT_W))) begin : g_bad_bl
    $error("write_burst_serializer: BURST_LENGTH does not fit the beat counter");
  end

  wr_ser_state_t           r_state;
  wr_ser_state_t           w_state_next;
  logic [C_LAT_W-1:0]      r_lat_cnt;
  logic [C_LAT_W-1:0]      w_lat_next;
  logic [C_BEAT_CNT_W-1:0] r_beat_cnt;
  logic [C_BEAT_CNT_W-1:0] w_beat_next;
  logic                    w_enter_burst;
  logic                    w_last_beat;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_load;
  logic                    w_underrun_next;

  logic [DATA_WIDTH-1:0]   r_hold;
  logic                    r_hold_valid;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_underrun_flag;
  logic [DRAM_WIDTH-1:0]   r_dq;
  logic                    r_dm;
  logic                    r_dqs_en;
  logic                    r_done;
  logic                    r_underrun_pulse;
  logic                    r_cmd_error;

  // A command is only legal when the PHY is free or about to be free.
  assign w_last_beat     = (r_state == ST_BURST) && (r_beat_cnt == C_LAST_BEAT);
  assign w_accept        = bus.wr_start && ((r_state == ST_IDLE) || w_last_beat);
  assign w_drop          = bus.wr_start && !w_accept;
  assign w_load          = bus.write_data_valid && !r_hold_valid;
  assign w_underrun_next = w_enter_burst ? !r_hold_valid : r_underrun_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lat_cnt  <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_lat_cnt  <= w_lat_next;
      r_beat_cnt <= w_beat_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_lat_next    = r_lat_cnt;
    w_beat_next   = r_beat_cnt;
    w_enter_burst = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_beat_next = '0;
      end
      ST_WAIT_WL: begin
        if (r_lat_cnt == '0) begin
          w_state_next  = ST_BURST;
          w_enter_burst = 1'b1;
          w_beat_next   = '0;
        end else begin
          w_lat_next = r_lat_cnt - 1'b1;
        end
      end
      ST_BURST: begin
        if (w_last_beat) begin
          w_state_next = ST_IDLE;
          w_beat_next  = '0;
        end else begin
          w_beat_next = r_beat_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_beat_next  = '0;
      end
    endcase
    if (w_accept) begin
      if (WRITE_LATENCY == 1) begin
        w_state_next  = ST_BURST;
        w_enter_burst = 1'b1;
        w_beat_next   = '0;
      end else begin
        w_state_next = ST_WAIT_WL;
        w_lat_next   = C_LAT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold           <= '0;
      r_hold_valid     <= 1'b0;
      r_shift          <= '0;
      r_underrun_flag  <= 1'b0;
      r_dq             <= '0;
      r_dm             <= 1'b0;
      r_dqs_en         <= 1'b0;
      r_done           <= 1'b0;
      r_underrun_pulse <= 1'b0;
      r_cmd_error      <= 1'b0;
    end else begin
      // Load wins over clear: both only coincide when the hold was already empty.
      if (w_load) begin
        r_hold       <= bus.write_data;
        r_hold_valid <= 1'b1;
      end else if (w_enter_burst) begin
        r_hold_valid <= 1'b0;
      end

      if (w_enter_burst) begin
        r_underrun_flag <= !r_hold_valid;
        if (r_hold_valid) begin
          r_dq    <= r_hold[DRAM_WIDTH-1:0];
          r_shift <= r_hold >> DRAM_WIDTH;
          r_dm    <= 1'b0;
        end else begin
          r_dq    <= '0;
          r_shift <= '0;
          r_dm    <= 1'b1;
        end
      end else if (w_state_next == ST_BURST) begin
        r_dq    <= r_shift[DRAM_WIDTH-1:0];
        r_shift <= r_shift >> DRAM_WIDTH;
      end else begin
        r_dq <= '0;
        r_dm <= 1'b0;
      end

      r_dqs_en         <= (w_state_next == ST_BURST);
      r_done           <= (w_state_next == ST_BURST) && (w_beat_next == C_LAST_BEAT);
      r_underrun_pulse <= (w_state_next == ST_BURST) && (w_beat_next == C_LAST_BEAT)
                          && w_underrun_next;
      r_cmd_error      <= w_drop;
    end
  end

  assign bus.write_data_ready = !r_hold_valid;
  assign bus.phy_wr_dq        = r_dq;
  assign bus.phy_wr_dm        = r_dm;
  assign bus.phy_wr_dqs_en    = r_dqs_en;
  assign bus.phy_burst_cnt    = r_beat_cnt;
  assign bus.wr_done          = r_done;
  assign bus.wr_underrun      = r_underrun_pulse;
  assign bus.cmd_error        = r_cmd_error;
  assign bus.busy             = (r_state != ST_IDLE);

endmodule : write_burst_serializer
`default_nettype wire

// File: tb/tb_write_burst_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_write_burst_serializer : scoreboard bench for WL=5 and WL=1 instances
// Rev 1.0
// ============================================================================
module tb_write_burst_serializer;
  import ddr3_pkg::*;

  localparam int C_WL0 = 5;
  localparam int C_WL1 = 1;

  typedef struct {
    int         cyc;
    logic [7:0] dq;
    logic       dm;
    logic [3:0] cnt;
    logic       done;
    logic       ur;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  int   exp_err_cyc [2];
  beat_t q [2][$];

  write_burst_serializer_if #(.DATA_WIDTH(64), .DRAM_WIDTH(8)) bus0 ();
  write_burst_serializer_if #(.DATA_WIDTH(64), .DRAM_WIDTH(8)) bus1 ();

  write_burst_serializer #(
    .DATA_WIDTH(64), .DRAM_WIDTH(8), .BURST_LENGTH(8), .WRITE_LATENCY(C_WL0)
  ) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  write_burst_serializer #(
    .DATA_WIDTH(64), .DRAM_WIDTH(8), .BURST_LENGTH(8), .WRITE_LATENCY(C_WL1)
  ) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int i, input logic v);
    if (i == 0) bus0.wr_start = v; else bus1.wr_start = v;
  endtask

  function automatic logic ready_of(input int i);
    return (i == 0) ? bus0.write_data_ready : bus1.write_data_ready;
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? bus0.busy : bus1.busy;
  endfunction

  task automatic load_word(input int i, input logic [63:0] w);
    for (int n = 0; n < 60; n++) begin
      if (ready_of(i) === 1'b1) begin
        if (i == 0) begin bus0.write_data = w; bus0.write_data_valid = 1'b1; end
        else        begin bus1.write_data = w; bus1.write_data_valid = 1'b1; end
        step();
        if (i == 0) bus0.write_data_valid = 1'b0; else bus1.write_data_valid = 1'b0;
        check($sformatf("ready_full%0d", i), ready_of(i), 1'b0);
        return;
      end
      step();
    end
    check($sformatf("load_timeout%0d", i), 1'b1, 1'b0);
  endtask

  // Drives wr_start for one cycle and queues the eight beats the burst must produce.
  task automatic issue_start(input int i, input logic [63:0] w, input bit has_data);
    int    wl;
    beat_t e;
    wl = (i == 0) ? C_WL0 : C_WL1;
    set_start(i, 1'b1);
    for (int k = 0; k < 8; k++) begin
      e.cyc  = cyc + wl + k;
      e.dq   = has_data ? w[k*8 +: 8] : 8'h00;
      e.dm   = !has_data;
      e.cnt  = 4'(k);
      e.done = (k == 7);
      e.ur   = (k == 7) && !has_data;
      q[i].push_back(e);
    end
    step();
    set_start(i, 1'b0);
  endtask

  task automatic drain(input int i);
    for (int n = 0; n < 60; n++) begin
      if ((q[i].size() == 0) && (busy_of(i) == 1'b0)) return;
      step();
    end
    check($sformatf("drain_timeout%0d", i), 1'b1, 1'b0);
  endtask

  task automatic run_basic(input int i, input logic [63:0] w);
    load_word(i, w);
    issue_start(i, w, 1'b1);
    check($sformatf("busy_after_start%0d", i), busy_of(i), 1'b1);
    drain(i);
    check($sformatf("ready_after_burst%0d", i), ready_of(i), 1'b1);
  endtask

  task automatic monitor(input int i, input logic en, input logic [7:0] dq, input logic dm,
                         input logic [3:0] cnt, input logic done, input logic ur,
                         input logic cerr);
    beat_t e;
    check($sformatf("cmd_error%0d", i), cerr, (cyc == exp_err_cyc[i]));
    if (en) begin
      if ((q[i].size() > 0) && (q[i][0].cyc == cyc)) begin
        e = q[i].pop_front();
        check($sformatf("dq%0d_b%0d", i, e.cnt), dq, e.dq);
        check($sformatf("dm%0d_b%0d", i, e.cnt), dm, e.dm);
        check($sformatf("burst_cnt%0d", i), cnt, e.cnt);
        check($sformatf("wr_done%0d_b%0d", i, e.cnt), done, e.done);
        check($sformatf("wr_underrun%0d_b%0d", i, e.cnt), ur, e.ur);
      end else begin
        check($sformatf("unexpected_beat%0d", i), en, 1'b0);
      end
    end else begin
      check($sformatf("idle_flags%0d", i), {done, ur, cnt}, 6'd0);
      if ((q[i].size() > 0) && (q[i][0].cyc == cyc)) begin
        check($sformatf("missing_beat%0d", i), en, 1'b1);
        void'(q[i].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor(0, bus0.phy_wr_dqs_en, bus0.phy_wr_dq, bus0.phy_wr_dm, bus0.phy_burst_cnt,
              bus0.wr_done, bus0.wr_underrun, bus0.cmd_error);
      monitor(1, bus1.phy_wr_dqs_en, bus1.phy_wr_dq, bus1.phy_wr_dm, bus1.phy_burst_cnt,
              bus1.wr_done, bus1.wr_underrun, bus1.cmd_error);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    exp_err_cyc[0] = -1;
    exp_err_cyc[1] = -1;
    bus0.write_data = '0; bus0.write_data_valid = 1'b0; bus0.wr_start = 1'b0;
    bus1.write_data = '0; bus1.write_data_valid = 1'b0; bus1.wr_start = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    check("rst_ready", bus0.write_data_ready, 1'b1);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_dqs_en", bus0.phy_wr_dqs_en, 1'b0);
    check("rst_dq_dm", {bus0.phy_wr_dq, bus0.phy_wr_dm}, 9'd0);
    check("rst_flags", {bus0.wr_done, bus0.wr_underrun, bus0.cmd_error, bus0.phy_burst_cnt}, 7'd0);
    check("rst_ready1", bus1.write_data_ready, 1'b1);
    mon_en = 1'b1;

    // Single burst, WL=5
    run_basic(0, 64'h8877_6655_4433_2211);

    // Underrun: hold empty
    issue_start(0, 64'h0, 1'b0);
    drain(0);

    // Back-to-back with a second word queued during the first burst
    load_word(0, 64'h0102_0304_0506_0708);
    t = cyc;
    issue_start(0, 64'h0102_0304_0506_0708, 1'b1);
    while (cyc < t + 5) step();
    load_word(0, 64'hA1B2_C3D4_E5F6_0718);
    while (cyc < t + 12) step();
    check("ready_held_b2b", bus0.write_data_ready, 1'b0);
    issue_start(0, 64'hA1B2_C3D4_E5F6_0718, 1'b1);
    check("ready_wait_b2b", bus0.write_data_ready, 1'b0);
    while (cyc < t + 17) step();
    check("ready_freed_b2b", bus0.write_data_ready, 1'b1);
    drain(0);

    // Dropped command during WAIT_WL
    load_word(0, 64'hDEAD_BEEF_CAFE_F00D);
    t = cyc;
    issue_start(0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    while (cyc < t + 3) step();
    set_start(0, 1'b1);
    exp_err_cyc[0] = t + 4;
    step();
    set_start(0, 1'b0);
    drain(0);

    // Reset at beat 3, with a coincident wr_start that must be ignored
    load_word(0, 64'h1122_3344_5566_7788);
    t = cyc;
    issue_start(0, 64'h1122_3344_5566_7788, 1'b1);
    while (cyc < t + 8) step();
    reset = 1'b1;
    set_start(0, 1'b1);
    while ((q[0].size() > 0) && (q[0][$].cyc > t + 8)) void'(q[0].pop_back());
    step();
    reset = 1'b0;
    set_start(0, 1'b0);
    check("post_rst_dqs_en", bus0.phy_wr_dqs_en, 1'b0);
    check("post_rst_busy", bus0.busy, 1'b0);
    check("post_rst_ready", bus0.write_data_ready, 1'b1);
    check("post_rst_done", bus0.wr_done, 1'b0);
    step();
    check("start_with_rst_ignored", bus0.busy, 1'b0);
    run_basic(0, 64'h8877_6655_4433_2211);

    // WL=1 instance
    run_basic(1, 64'hF0E1_D2C3_B4A5_9687);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_write_burst_serializer
`default_nettype wire
